control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the 32-bit bus-based datapath. It drives every datapath strobe: register-file select and enables, bus-source enables, memory Read/Write, ALU operation, CON FF load and I/O port strobes. Each instruction runs as a three-step fetch followed by a per-opcode execute sequence. It replaces testbench-driven control sequences and sits beside the datapath, sampling IR and the CON flip-flop output.

## Interface
Parameters:
- MEM_HANDSHAKE, 1, when 1 memory steps hold until MemDone=1; when 0 MemDone is ignored and treated as 1.

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Clear  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON_FF  in  1  branch-condition flip-flop output
- MemDone  in  1  memory completion for the current Read/Write step
- Stop  in  1  request to halt at the next instruction boundary
- PCout, Zhighout, Zlowout, MDRout, InPortout, BAout, Cout  out  1 each  bus-source enables
- MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONin  out  1 each  register load enables
- IncPC, Read, Write  out  1 each  PC increment, memory read, memory write
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file field select and enables
- AluOp  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR
- Run  out  1  1 while executing; 0 in RESET_S and HALT_S

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, jr 10011, in 10110, out 10111, nop 11010, halt 11011. Any other opcode is illegal and goes to HALT_S.
- States: RESET_S, T0–T7, HALT_S. Outputs are decoded from the present state and, in T3–T7, from IR[31:27]. Every output not listed for a step is 0. AluOp defaults to ADD.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Wait for MemDone.
  - T2: MDRout, IRin.
- add/sub/and/or: T3 Grb,Rout,Yin. T4 Grc,Rout,Zin,AluOp=op. T5 Zlowout,Gra,Rin, then T0.
- addi/andi/ori: T3 Grb,Rout,Yin. T4 Cout,Zin,AluOp=op. T5 Zlowout,Gra,Rin, then T0.
- ldi: T3 Grb,BAout,Yin. T4 Cout,Zin (ADD). T5 Zlowout,Gra,Rin, then T0.
- ld:
  - T3–T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin. Wait for MemDone.
  - T7: MDRout, Gra, Rin, then T0.
- st:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (Read=0, so MDR loads from the bus).
  - T7: Write. Wait for MemDone, then T0.
- br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin (ADD).
  - T6: Zlowout, PCin=CON_FF, then T0.
- jr: T3 Gra,Rout,PCin, then T0.
- in: T3 InPortout,Gra,Rin, then T0.
- out: T3 Gra,Rout,OutPortin, then T0.
- nop: T3 with no outputs, then T0.
- halt: T3, then HALT_S.
- Wait steps: if MEM_HANDSHAKE=1 and MemDone=0, the state holds and all outputs of that step stay asserted.
- Stop: whenever the next state would be T0 and Stop=1, the FSM enters HALT_S instead. The current instruction always completes.
- HALT_S: all outputs 0, Run=0. The FSM leaves HALT_S only through Clear.

## Timing
- Clear=1 forces RESET_S immediately, asynchronously, from any state including a memory wait. All outputs go to 0 and Run to 0 in the same cycle.
- The first rising edge with Clear=0 moves RESET_S to T0. Run=1 from T0 onward.
- Outputs change only after a Clock rising edge or on Clear. The datapath samples its enables on the following edge.
- Zero-wait latency: fetch 3 cycles. Execute: add/addi/ldi 3, ld/st 5, br 4, jr/in/out/nop 1.
- IR is sampled combinationally during T3–T7 only. IR changes outside these states have no effect.
- CON_FF is sampled only in br T6, on the edge that ends T6.
- MemDone is sampled only in T1, ld T6 and st T7. The step ends on the first edge where MemDone=1, so the minimum step length is 1 cycle.

## Test plan
- Clear pulse mid-T4 of add -> all outputs 0 and Run=0 immediately; T0 outputs (PCout,MARin,IncPC,Zin) appear 1 cycle after Clear falls.
- add R1,R2,R3 (IR=0x18918000), MemDone=1 -> exact strobes per step T0–T5, AluOp=0000 in T4, back to T0 on the 7th edge.
- brmi R2,35 (IR=0x91600023): CON_FF=1 -> PCin=1 in T6; CON_FF=0 -> PCin=0 in T6. CONin=1 only in T3.
- ld with MemDone held 0 for 3 cycles in T6 -> Read and MDRin stay 1 for 4 cycles; T7 asserts MDRout,Gra,Rin.
- st with MEM_HANDSHAKE=0 and MemDone=0 -> Write for exactly 1 cycle in T7; no stall.
- Stop=1 during add T4 -> add completes through T5, then HALT_S with Run=0. Opcode 11111 -> HALT_S after T3.

Source files
------------

// File: rtl/control_unit.sv
// Hardwired control sequencer: three-step fetch, then a per-opcode execute sequence.
// Moore outputs decoded from the present state (and opcode in T3-T7); memory steps may stall on MemDone.
module control_unit #(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic        Clock_i,
   input  logic        Clear_i,
   input  logic [31:0] IR_i,
   input  logic        CON_FF_i,
   input  logic        MemDone_i,
   input  logic        Stop_i,
   output logic        PCout_o,
   output logic        Zhighout_o,
   output logic        Zlowout_o,
   output logic        MDRout_o,
   output logic        InPortout_o,
   output logic        BAout_o,
   output logic        Cout_o,
   output logic        MARin_o,
   output logic        Zin_o,
   output logic        PCin_o,
   output logic        MDRin_o,
   output logic        IRin_o,
   output logic        Yin_o,
   output logic        OutPortin_o,
   output logic        CONin_o,
   output logic        IncPC_o,
   output logic        Read_o,
   output logic        Write_o,
   output logic        Gra_o,
   output logic        Grb_o,
   output logic        Grc_o,
   output logic        Rin_o,
   output logic        Rout_o,
   output logic [3:0]  AluOp_o,
   output logic        Run_o
);

   typedef enum logic [3:0] {
      RESET_S, T0, T1, T2, T3, T4, T5, T6, T7, HALT_S
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10010, OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010, ALU_OR  = 4'b0011;

   state_t     state_q, state_d;
   logic [4:0] opcode;
   logic       is_reg_alu, is_imm_alu, is_addr_calc, mem_ok;
   logic [3:0] alu_sel;
   logic       unused_ir;

   assign opcode       = IR_i[31:27];
   assign unused_ir    = ^IR_i[26:0];
   assign is_reg_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                         (opcode == OP_AND) || (opcode == OP_OR);
   assign is_imm_alu   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign is_addr_calc = (opcode == OP_LDI) || (opcode == OP_LD) || (opcode == OP_ST);
   // Without the handshake every memory step completes in a single cycle.
   assign mem_ok       = !MEM_HANDSHAKE || MemDone_i;

   always_comb begin
      alu_sel = ALU_ADD;
      case (opcode)
         OP_SUB:          alu_sel = ALU_SUB;
         OP_AND, OP_ANDI: alu_sel = ALU_AND;
         OP_OR,  OP_ORI:  alu_sel = ALU_OR;
         default:         alu_sel = ALU_ADD;
      endcase
   end

   always_ff @(posedge Clock_i or posedge Clear_i) begin
      if (Clear_i) state_q <= RESET_S;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      PCout_o     = 1'b0; Zhighout_o  = 1'b0; Zlowout_o = 1'b0; MDRout_o  = 1'b0;
      InPortout_o = 1'b0; BAout_o     = 1'b0; Cout_o    = 1'b0; MARin_o   = 1'b0;
      Zin_o       = 1'b0; PCin_o      = 1'b0; MDRin_o   = 1'b0; IRin_o    = 1'b0;
      Yin_o       = 1'b0; OutPortin_o = 1'b0; CONin_o   = 1'b0; IncPC_o   = 1'b0;
      Read_o      = 1'b0; Write_o     = 1'b0; Gra_o     = 1'b0; Grb_o     = 1'b0;
      Grc_o       = 1'b0; Rin_o       = 1'b0; Rout_o    = 1'b0; AluOp_o   = ALU_ADD;
      Run_o       = (state_q != RESET_S) && (state_q != HALT_S);

      case (state_q)
         RESET_S: state_d = T0;
         T0: begin
            PCout_o = 1'b1; MARin_o = 1'b1; IncPC_o = 1'b1; Zin_o = 1'b1;
            state_d = T1;
         end
         T1: begin
            Zlowout_o = 1'b1; PCin_o = 1'b1; Read_o = 1'b1; MDRin_o = 1'b1;
            if (mem_ok) state_d = T2;
         end
         T2: begin
            MDRout_o = 1'b1; IRin_o = 1'b1;
            state_d  = T3;
         end
         T3: begin
            if (is_reg_alu || is_imm_alu) begin
               Grb_o = 1'b1; Rout_o = 1'b1; Yin_o = 1'b1; state_d = T4;
            end else if (is_addr_calc) begin
               Grb_o = 1'b1; BAout_o = 1'b1; Yin_o = 1'b1; state_d = T4;
            end else begin
               case (opcode)
                  OP_BR:   begin Gra_o = 1'b1; Rout_o = 1'b1; CONin_o = 1'b1; state_d = T4; end
                  OP_JR:   begin Gra_o = 1'b1; Rout_o = 1'b1; PCin_o = 1'b1; state_d = T0; end
                  OP_IN:   begin InPortout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; state_d = T0; end
                  OP_OUT:  begin Gra_o = 1'b1; Rout_o = 1'b1; OutPortin_o = 1'b1; state_d = T0; end
                  OP_NOP:  state_d = T0;
                  default: state_d = HALT_S;
               endcase
            end
         end
         T4: begin
            if (is_reg_alu) begin
               Grc_o = 1'b1; Rout_o = 1'b1; Zin_o = 1'b1; AluOp_o = alu_sel; state_d = T5;
            end else if (is_imm_alu) begin
               Cout_o = 1'b1; Zin_o = 1'b1; AluOp_o = alu_sel; state_d = T5;
            end else if (is_addr_calc) begin
               Cout_o = 1'b1; Zin_o = 1'b1; state_d = T5;
            end else if (opcode == OP_BR) begin
               PCout_o = 1'b1; Yin_o = 1'b1; state_d = T5;
            end else begin
               state_d = HALT_S;
            end
         end
         T5: begin
            if (is_reg_alu || is_imm_alu || opcode == OP_LDI) begin
               Zlowout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; state_d = T0;
            end else if (opcode == OP_LD || opcode == OP_ST) begin
               Zlowout_o = 1'b1; MARin_o = 1'b1; state_d = T6;
            end else if (opcode == OP_BR) begin
               Cout_o = 1'b1; Zin_o = 1'b1; state_d = T6;
            end else begin
               state_d = HALT_S;
            end
         end
         T6: begin
            case (opcode)
               OP_LD: begin
                  Read_o = 1'b1; MDRin_o = 1'b1;
                  if (mem_ok) state_d = T7;
               end
               OP_ST:   begin Gra_o = 1'b1; Rout_o = 1'b1; MDRin_o = 1'b1; state_d = T7; end
               OP_BR:   begin Zlowout_o = 1'b1; PCin_o = CON_FF_i; state_d = T0; end
               default: state_d = HALT_S;
            endcase
         end
         T7: begin
            case (opcode)
               OP_LD: begin MDRout_o = 1'b1; Gra_o = 1'b1; Rin_o = 1'b1; state_d = T0; end
               OP_ST: begin
                  Write_o = 1'b1;
                  if (mem_ok) state_d = T0;
               end
               default: state_d = HALT_S;
            endcase
         end
         HALT_S:  state_d = HALT_S;
         default: state_d = HALT_S;
      endcase

      // A pending Stop diverts every instruction boundary into HALT_S.
      if (state_d == T0 && Stop_i) state_d = HALT_S;
   end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobe vectors from an instruction-level step table.
module tb_control_unit;

   localparam logic [27:0] PCOUT = 28'd1 << 0,  ZHOUT = 28'd1 << 1,  ZLOWOUT = 28'd1 << 2;
   localparam logic [27:0] MDROUT = 28'd1 << 3, INPORTOUT = 28'd1 << 4, BAOUT = 28'd1 << 5;
   localparam logic [27:0] COUT = 28'd1 << 6,   MARIN = 28'd1 << 7,  ZIN = 28'd1 << 8;
   localparam logic [27:0] PCIN = 28'd1 << 9,   MDRIN = 28'd1 << 10, IRIN = 28'd1 << 11;
   localparam logic [27:0] YIN = 28'd1 << 12,   OUTPORTIN = 28'd1 << 13, CONIN = 28'd1 << 14;
   localparam logic [27:0] INCPC = 28'd1 << 15, READ = 28'd1 << 16, WRITE = 28'd1 << 17;
   localparam logic [27:0] GRA = 28'd1 << 18,   GRB = 28'd1 << 19,  GRC = 28'd1 << 20;
   localparam logic [27:0] RIN = 28'd1 << 21,   ROUT = 28'd1 << 22, RUN = 28'd1 << 27;

   logic        clk = 1'b0;
   logic        clr0, clr1, con_ff, mem_done, stop;
   logic [31:0] ir;
   logic [27:0] o0, o1;

   always #5 clk = ~clk;

   control_unit #(.MEM_HANDSHAKE(1'b1)) u_hs (
      .Clock_i(clk), .Clear_i(clr0), .IR_i(ir), .CON_FF_i(con_ff), .MemDone_i(mem_done), .Stop_i(stop),
      .PCout_o(o0[0]), .Zhighout_o(o0[1]), .Zlowout_o(o0[2]), .MDRout_o(o0[3]), .InPortout_o(o0[4]),
      .BAout_o(o0[5]), .Cout_o(o0[6]), .MARin_o(o0[7]), .Zin_o(o0[8]), .PCin_o(o0[9]),
      .MDRin_o(o0[10]), .IRin_o(o0[11]), .Yin_o(o0[12]), .OutPortin_o(o0[13]), .CONin_o(o0[14]),
      .IncPC_o(o0[15]), .Read_o(o0[16]), .Write_o(o0[17]), .Gra_o(o0[18]), .Grb_o(o0[19]),
      .Grc_o(o0[20]), .Rin_o(o0[21]), .Rout_o(o0[22]), .AluOp_o(o0[26:23]), .Run_o(o0[27])
   );

   control_unit #(.MEM_HANDSHAKE(1'b0)) u_nh (
      .Clock_i(clk), .Clear_i(clr1), .IR_i(ir), .CON_FF_i(con_ff), .MemDone_i(mem_done), .Stop_i(stop),
      .PCout_o(o1[0]), .Zhighout_o(o1[1]), .Zlowout_o(o1[2]), .MDRout_o(o1[3]), .InPortout_o(o1[4]),
      .BAout_o(o1[5]), .Cout_o(o1[6]), .MARin_o(o1[7]), .Zin_o(o1[8]), .PCin_o(o1[9]),
      .MDRin_o(o1[10]), .IRin_o(o1[11]), .Yin_o(o1[12]), .OutPortin_o(o1[13]), .CONin_o(o1[14]),
      .IncPC_o(o1[15]), .Read_o(o1[16]), .Write_o(o1[17]), .Gra_o(o1[18]), .Grb_o(o1[19]),
      .Grc_o(o1[20]), .Rin_o(o1[21]), .Rout_o(o1[22]), .AluOp_o(o1[26:23]), .Run_o(o1[27])
   );

   int          checks = 0;
   int          errors = 0;
   bit          sel;
   logic [27:0] exp_q[$];
   string       tag_q[$];
   string       cur_tag;
   logic [27:0] seq[$];
   bit          memf[$];
   bit          to_halt;
   logic [27:0] mon_exp, mon_act;
   string       mon_tag;
   logic [4:0]  legal [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                               5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b10010, 5'b10011,
                               5'b10110, 5'b10111, 5'b11010, 5'b11011};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_act = sel ? o1 : o0;
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL %s t=%0t dut_nohs=%0d actual=%h required=%h", mon_tag, $time, sel, mon_act, mon_exp);
         end
      end
   end

   function automatic logic [27:0] alu(input logic [3:0] a);
      return {1'b0, a, 23'd0};
   endfunction

   task automatic cyc(input logic [27:0] e);
      exp_q.push_back(e);
      tag_q.push_back(cur_tag);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [27:0] m, input bit mem);
      seq.push_back(m);
      memf.push_back(mem);
   endtask

   // Instruction-level step table: fetch, then the execute steps for the opcode.
   task automatic build(input logic [4:0] op, input bit con);
      logic [3:0] a;
      seq.delete(); memf.delete(); to_halt = 1'b0;
      step(PCOUT | MARIN | INCPC | ZIN, 1'b0);
      step(ZLOWOUT | PCIN | READ | MDRIN, 1'b1);
      step(MDROUT | IRIN, 1'b0);
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
            a = 4'(op - 5'd3);
            step(GRB | ROUT | YIN, 1'b0);
            step(GRC | ROUT | ZIN | alu(a), 1'b0);
            step(ZLOWOUT | GRA | RIN, 1'b0);
         end
         5'b01100, 5'b01101, 5'b01110: begin
            a = (op == 5'b01100) ? 4'd0 : (op == 5'b01101) ? 4'd2 : 4'd3;
            step(GRB | ROUT | YIN, 1'b0);
            step(COUT | ZIN | alu(a), 1'b0);
            step(ZLOWOUT | GRA | RIN, 1'b0);
         end
         5'b00001: begin
            step(GRB | BAOUT | YIN, 1'b0);
            step(COUT | ZIN, 1'b0);
            step(ZLOWOUT | GRA | RIN, 1'b0);
         end
         5'b00000, 5'b00010: begin
            step(GRB | BAOUT | YIN, 1'b0);
            step(COUT | ZIN, 1'b0);
            step(ZLOWOUT | MARIN, 1'b0);
            if (op == 5'b00000) begin
               step(READ | MDRIN, 1'b1);
               step(MDROUT | GRA | RIN, 1'b0);
            end else begin
               step(GRA | ROUT | MDRIN, 1'b0);
               step(WRITE, 1'b1);
            end
         end
         5'b10010: begin
            step(GRA | ROUT | CONIN, 1'b0);
            step(PCOUT | YIN, 1'b0);
            step(COUT | ZIN, 1'b0);
            step(ZLOWOUT | (con ? PCIN : 28'd0), 1'b0);
         end
         5'b10011: step(GRA | ROUT | PCIN, 1'b0);
         5'b10110: step(INPORTOUT | GRA | RIN, 1'b0);
         5'b10111: step(GRA | ROUT | OUTPORTIN, 1'b0);
         5'b11010: step(28'd0, 1'b0);
         default: begin
            step(28'd0, 1'b0);
            to_halt = 1'b1;
         end
      endcase
   endtask

   task automatic do_clear();
      cur_tag = "clear";
      if (sel) clr1 = 1'b1; else clr0 = 1'b1;
      stop = 1'b0;
      cyc(28'd0);
      clr0 = sel ? 1'b1 : 1'b0;
      clr1 = sel ? 1'b0 : 1'b1;
      cur_tag = "reset_release";
      cyc(28'd0);
   endtask

   task automatic idle_halt();
      cur_tag = "halt_idle";
      repeat (3) begin
         ir = $urandom; stop = 1'($urandom); mem_done = 1'($urandom); con_ff = 1'($urandom);
         cyc(28'd0);
      end
      do_clear();
   endtask

   // DUT must be in T0 on entry. dly<0 picks a random MemDone=0 run per memory step.
   task automatic run_instr(input logic [31:0] instr, input bit con, input int dly,
                            input int stop_at, input int abort_at);
      int  n;
      bit  halted;
      build(instr[31:27], con);
      con_ff = con;
      stop   = 1'b0;
      for (int i = 0; i < seq.size(); i++) begin
         cur_tag = $sformatf("op%05b_T%0d", instr[31:27], i);
         ir = (i < 3) ? $urandom : instr;
         if (i == abort_at) begin
            do_clear();
            return;
         end
         if (i >= stop_at) stop = 1'b1;
         n = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
         if (memf[i] && !sel) begin
            repeat (n) begin
               mem_done = 1'b0;
               cyc(seq[i] | RUN);
            end
            mem_done = 1'b1;
         end else if (memf[i]) begin
            mem_done = (n > 0) ? 1'b0 : 1'($urandom);
         end else begin
            mem_done = 1'($urandom);
         end
         cyc(seq[i] | RUN);
      end
      halted = to_halt || (stop_at < seq.size());
      stop = 1'b0;
      if (halted) idle_halt();
   endtask

   task automatic random_instr(input int count);
      logic [4:0]  op;
      logic [31:0] instr;
      int          st_at, ab_at;
      for (int k = 0; k < count; k++) begin
         op    = ($urandom_range(0, 19) == 0) ? 5'($urandom) : legal[$urandom_range(0, 15)];
         instr = {op, 27'($urandom)};
         st_at = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : 99;
         ab_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : 99;
         run_instr(instr, 1'($urandom), -1, st_at, ab_at);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel = 1'b0; clr0 = 1'b1; clr1 = 1'b1;
      ir = 32'd0; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0;
      cur_tag = "init";
      @(posedge clk);
      #1;
      do_clear();

      run_instr(32'h18918000, 1'b0, 0, 99, 99);   // add R1,R2,R3
      run_instr(32'h18918000, 1'b0, 0, 99, 4);    // Clear during T4
      run_instr(32'h91600023, 1'b1, 0, 99, 99);   // br taken
      run_instr(32'h91600023, 1'b0, 0, 99, 99);   // br not taken
      run_instr(32'h00880000, 1'b0, 3, 99, 99);   // ld with 3-cycle memory stalls
      run_instr(32'h10880000, 1'b0, 2, 99, 99);   // st with stalls
      run_instr(32'h18918000, 1'b0, 0, 4, 99);    // Stop raised in T4
      run_instr(32'hF8000000, 1'b0, 0, 99, 99);   // illegal opcode
      run_instr(32'hD8000000, 1'b0, 0, 99, 99);   // halt
      random_instr(150);

      clr0 = 1'b1;
      sel  = 1'b1;
      do_clear();
      run_instr(32'h10880000, 1'b0, 5, 99, 99);   // st, MemDone ignored
      run_instr(32'h00880000, 1'b0, 5, 99, 99);   // ld, MemDone ignored
      random_instr(50);

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
